// File: rtl/prom_param_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prom_param_loader
//  Description : Reads the parameter PROM byte stream after reset or on
//                START: waits out the PROM first-data latency, checks the
//                two-byte signature, reads the word count, writes
//                little-endian 16-bit words to the parameter register file
//                and verifies the trailing 8-bit checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module prom_param_loader #(
    parameter logic [7:0] SIG0      = 8'hDC,
    parameter logic [7:0] SIG1      = 8'hFB,
    parameter int         FIRST_LAT = 4,
    parameter int         MAX_WORDS = 64,
    localparam int        AW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
    input  logic          CLK20,
    input  logic          RST_B,
    input  logic          START,
    input  logic [7:0]    PARAM_DAT,
    output logic          PROM_CE,
    output logic          PROM_OE,
    output logic          WR_EN,
    output logic [AW-1:0] WR_ADDR,
    output logic [15:0]   WR_DATA,
    output logic          BUSY,
    output logic          DONE,
    output logic [1:0]    ERR
);

    // Latency counter preload: LAT state lasts exactly FIRST_LAT cycles.
    localparam logic [3:0] c_LAT_INIT = 4'(FIRST_LAT - 1);
    localparam logic [7:0] c_MAX_N    = 8'(MAX_WORDS);

    localparam logic [1:0] c_ERR_SIG  = 2'd1;
    localparam logic [1:0] c_ERR_LEN  = 2'd2;
    localparam logic [1:0] c_ERR_CSUM = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LAT  = 4'd1,
        S_SIG0 = 4'd2,
        S_SIG1 = 4'd3,
        S_LEN  = 4'd4,
        S_LO   = 4'd5,
        S_HI   = 4'd6,
        S_CSUM = 4'd7,
        S_FIN  = 4'd8,
        S_FAIL = 4'd9
    } state_t;

    // Registered state and datapath
    state_t          r_state;
    logic            r_boot;      // pending self-start after reset release
    logic [3:0]      r_lat;
    logic [AW-1:0]   r_cnt;       // current word index
    logic [AW-1:0]   r_last;      // word count minus one
    logic [7:0]      r_lo;
    logic [7:0]      r_sum;       // running sum of LEN and data bytes
    logic            r_ce;
    logic            r_oe;
    logic            r_busy;
    logic            r_done;
    logic [1:0]      r_err;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [15:0]     r_wr_data;

    // Next-state values
    state_t          w_state;
    logic [3:0]      w_lat;
    logic [AW-1:0]   w_cnt;
    logic [AW-1:0]   w_last;
    logic [7:0]      w_lo;
    logic [7:0]      w_sum;
    logic            w_ce;
    logic            w_busy;
    logic            w_done;
    logic [1:0]      w_err;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [15:0]     w_wr_data;
    logic [7:0]      w_sum_byte;
    logic            w_start;

    assign w_sum_byte = r_sum + PARAM_DAT;
    assign w_start    = START | r_boot;

    // State and output registers; reset leaves everything idle and arms the self-start.
    always_ff @(posedge CLK20 or negedge RST_B) begin
        if (!RST_B) begin
            r_state   <= S_IDLE;
            r_boot    <= 1'b1;
            r_lat     <= 4'd0;
            r_cnt     <= '0;
            r_last    <= '0;
            r_lo      <= 8'd0;
            r_sum     <= 8'd0;
            r_ce      <= 1'b0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 2'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 16'd0;
        end else begin
            r_state   <= w_state;
            r_boot    <= 1'b0;
            r_lat     <= w_lat;
            r_cnt     <= w_cnt;
            r_last    <= w_last;
            r_lo      <= w_lo;
            r_sum     <= w_sum;
            r_ce      <= w_ce;
            r_oe      <= w_ce;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= w_err;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
        end
    end

    // Next-state and next-output decode; one PROM byte is consumed per cycle in byte states.
    always_comb begin
        w_state   = r_state;
        w_lat     = r_lat;
        w_cnt     = r_cnt;
        w_last    = r_last;
        w_lo      = r_lo;
        w_sum     = r_sum;
        w_ce      = r_ce;
        w_busy    = r_busy;
        w_done    = r_done;
        w_err     = r_err;
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;

        case (r_state)
            S_IDLE: begin
                w_ce = 1'b0;
                if (w_start) begin
                    w_done  = 1'b0;
                    w_err   = 2'd0;
                    w_busy  = 1'b1;
                    w_ce    = 1'b1;
                    w_lat   = c_LAT_INIT;
                    w_sum   = 8'd0;
                    w_state = S_LAT;
                end
            end
            S_LAT: begin
                if (r_lat == 4'd0) begin
                    w_state = S_SIG0;
                end else begin
                    w_lat = r_lat - 4'd1;
                end
            end
            S_SIG0: begin
                if (PARAM_DAT != SIG0) begin
                    w_err   = c_ERR_SIG;
                    w_state = S_FAIL;
                end else begin
                    w_state = S_SIG1;
                end
            end
            S_SIG1: begin
                if (PARAM_DAT != SIG1) begin
                    w_err   = c_ERR_SIG;
                    w_state = S_FAIL;
                end else begin
                    w_state = S_LEN;
                end
            end
            S_LEN: begin
                if ((PARAM_DAT == 8'd0) || (PARAM_DAT > c_MAX_N)) begin
                    w_err   = c_ERR_LEN;
                    w_state = S_FAIL;
                end else begin
                    w_last  = AW'(PARAM_DAT - 8'd1);
                    w_cnt   = '0;
                    w_sum   = PARAM_DAT;
                    w_state = S_LO;
                end
            end
            S_LO: begin
                w_lo    = PARAM_DAT;
                w_sum   = w_sum_byte;
                w_state = S_HI;
            end
            S_HI: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_cnt;
                w_wr_data = {PARAM_DAT, r_lo};
                w_sum     = w_sum_byte;
                if (r_cnt == r_last) begin
                    w_state = S_CSUM;
                end else begin
                    w_cnt   = r_cnt + AW'(1);
                    w_state = S_LO;
                end
            end
            S_CSUM: begin
                // A correct checksum byte brings the running sum to zero.
                if (w_sum_byte == 8'd0) begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_ce    = 1'b0;
                    w_state = S_FIN;
                end else begin
                    w_err   = c_ERR_CSUM;
                    w_state = S_FAIL;
                end
            end
            S_FIN: begin
                w_state = S_IDLE;
            end
            S_FAIL: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Any transition into FAIL ends the load with outputs released.
        if ((w_state == S_FAIL) && (r_state != S_FAIL)) begin
            w_done = 1'b0;
            w_busy = 1'b0;
            w_ce   = 1'b0;
        end
    end

    assign PROM_CE = r_ce;
    assign PROM_OE = r_oe;
    assign WR_EN   = r_wr_en;
    assign WR_ADDR = r_wr_addr;
    assign WR_DATA = r_wr_data;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign ERR     = r_err;

endmodule
`default_nettype wire
